// File: rtl/memlibc_memory_bist_assembly_rtl_tessent_clk_en_pkg.sv
// rtl/memlibc_memory_bist_assembly_rtl_tessent_clk_en_pkg.sv - shared types for the MBIST clock-enable sequencer
package memlibc_memory_bist_assembly_rtl_tessent_clk_en_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/memlibc_memory_bist_assembly_rtl_tessent_clk_en_timer.sv
// rtl/memlibc_memory_bist_assembly_rtl_tessent_clk_en_timer.sv - loadable down-counter with zero flag
module memlibc_memory_bist_assembly_rtl_tessent_clk_en_timer
    import memlibc_memory_bist_assembly_rtl_tessent_clk_en_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_count;

    // Load wins over decrement; the count parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/blk_cc4863.sv
// rtl/blk_cc4863.sv - MBIST clock-enable sequencer: warm-up, ack, drain, scan override, run counter
module blk_cc4863
    import memlibc_memory_bist_assembly_rtl_tessent_clk_en_pkg::*;
#(
    parameter int WARMUP_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 4,
    parameter int RUN_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 scan_en,
    output logic                 clk_en,
    output logic                 ack,
    output logic                 busy,
    output logic [RUN_CNT_W-1:0] run_cnt
);

    if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
        $fatal(1, "WARMUP_CYCLES must be in 1..255");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
        $fatal(1, "DRAIN_CYCLES must be in 1..255");
    end

    localparam logic [TIMER_W-1:0] WARM_LD  = TIMER_W'(WARMUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LD = TIMER_W'(DRAIN_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_clk_en_q;
    logic                   r_ack;
    logic                   r_busy;
    logic [RUN_CNT_W-1:0]   r_run_cnt;
    logic                   w_load;
    logic [TIMER_W-1:0]     w_load_val;
    logic                   w_dec;
    logic                   w_zero;

    memlibc_memory_bist_assembly_rtl_tessent_clk_en_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = WARMUP;
                    w_load      = 1'b1;
                    w_load_val  = WARM_LD;
                end
            end
            WARMUP: begin
                if (!req) begin
                    w_state_nxt = DRAIN;
                    w_load      = 1'b1;
                    w_load_val  = DRAIN_LD;
                end else if (w_zero) begin
                    w_state_nxt = ACTIVE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ACTIVE: begin
                if (!req) begin
                    w_state_nxt = DRAIN;
                    w_load      = 1'b1;
                    w_load_val  = DRAIN_LD;
                end
            end
            DRAIN: begin
                // The clock never stopped, so a re-request skips warm-up.
                if (req) begin
                    w_state_nxt = ACTIVE;
                end else if (w_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_clk_en_q <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_en_q <= (w_state_nxt != IDLE);
            r_ack      <= (w_state_nxt == ACTIVE);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    // Counts cycles the gated clock actually ran; the scan term is excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_cnt <= '0;
        end else if ((r_state == IDLE) && (w_state_nxt == WARMUP)) begin
            r_run_cnt <= '0;
        end else if (r_clk_en_q && (r_run_cnt != {RUN_CNT_W{1'b1}})) begin
            r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);
        end
    end

    assign clk_en  = r_clk_en_q | scan_en;
    assign ack     = r_ack;
    assign busy    = r_busy;
    assign run_cnt = r_run_cnt;

endmodule

// File: tb/tb_blk_cc4863.sv
// tb/tb_blk_cc4863.sv - directed self-checking bench for blk_cc4863
module tb_blk_cc4863;

    logic       clk;
    logic       reset;
    logic       req;
    logic       scan_en;
    logic       clk_en;
    logic       ack;
    logic       busy;
    logic [3:0] run_cnt;

    int checks = 0;
    int errors = 0;

    blk_cc4863 #(
        .WARMUP_CYCLES (4),
        .DRAIN_CYCLES  (4),
        .RUN_CNT_W     (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .scan_en (scan_en),
        .clk_en  (clk_en),
        .ack     (ack),
        .busy    (busy),
        .run_cnt (run_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 1'b0;
        scan_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 1'b0;
        scan_en = 1'b0;
        tick();
        checks++;
        if ({clk_en, ack, busy, run_cnt} !== 7'b0) begin
            errors++;
            $display("FAIL reset_state got en=%b ack=%b busy=%b cnt=%0d exp all 0", clk_en, ack, busy, run_cnt);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({clk_en, ack, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset got en=%b ack=%b busy=%b exp 000", clk_en, ack, busy);
        end
    endtask

    task automatic test_warmup();
        logic exp_ack;
        do_reset();
        req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_ack = (k >= 5);
            checks++;
            if (clk_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL warmup_en_busy cyc %0d got en=%b busy=%b exp 1 1", k, clk_en, busy);
            end
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL warmup_ack cyc %0d got %b exp %b", k, ack, exp_ack);
            end
            checks++;
            if (run_cnt !== 4'(k - 1)) begin
                errors++;
                $display("FAIL warmup_run_cnt cyc %0d got %0d exp %0d", k, run_cnt, k - 1);
            end
        end
    endtask

    task automatic test_release();
        logic exp_en;
        req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_en = (k <= 4);
            checks++;
            if (ack !== 1'b0) begin
                errors++;
                $display("FAIL release_ack cyc N+%0d got %b exp 0", k, ack);
            end
            checks++;
            if (clk_en !== exp_en || busy !== exp_en) begin
                errors++;
                $display("FAIL release_en_busy cyc N+%0d got en=%b busy=%b exp %b", k, clk_en, busy, exp_en);
            end
        end
        checks++;
        if (run_cnt !== 4'd10) begin
            errors++;
            $display("FAIL release_run_cnt_hold got %0d exp 10", run_cnt);
        end
    endtask

    task automatic test_abort();
        logic exp_en;
        do_reset();
        req = 1'b1;
        tick();
        req = 1'b0;
        checks++;
        if (clk_en !== 1'b1 || ack !== 1'b0 || run_cnt !== 4'd0) begin
            errors++;
            $display("FAIL abort_start got en=%b ack=%b cnt=%0d exp 1 0 0", clk_en, ack, run_cnt);
        end
        for (int k = 2; k <= 7; k++) begin
            tick();
            exp_en = (k <= 5);
            checks++;
            if (clk_en !== exp_en || busy !== exp_en || ack !== 1'b0) begin
                errors++;
                $display("FAIL abort_seq cyc %0d got en=%b busy=%b ack=%b exp %b %b 0", k, clk_en, busy, ack, exp_en, exp_en);
            end
        end
        checks++;
        if (run_cnt !== 4'd5) begin
            errors++;
            $display("FAIL abort_run_cnt got %0d exp 5", run_cnt);
        end
    endtask

    task automatic test_rerequest();
        do_reset();
        req = 1'b1;
        repeat (6) tick();
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || clk_en !== 1'b1) begin
            errors++;
            $display("FAIL rereq_drain1 got ack=%b en=%b exp 0 1", ack, clk_en);
        end
        tick();
        req = 1'b1;
        tick();
        checks++;
        if (ack !== 1'b1 || clk_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rereq_mid got ack=%b en=%b busy=%b exp 1 1 1", ack, clk_en, busy);
        end
        tick();
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (ack !== 1'b0 || clk_en !== 1'b1) begin
                errors++;
                $display("FAIL rereq_drain cyc M+%0d got ack=%b en=%b exp 0 1", k, ack, clk_en);
            end
        end
        req = 1'b1;
        tick();
        checks++;
        if (ack !== 1'b1 || clk_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rereq_at_zero got ack=%b en=%b busy=%b exp 1 1 1", ack, clk_en, busy);
        end
        tick();
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL rereq_hold got ack=%b exp 1", ack);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 15 || k == 16 || k == 17 || k == 30) begin
                checks++;
                if (run_cnt !== ((k >= 16) ? 4'd15 : 4'd14)) begin
                    errors++;
                    $display("FAIL sat_run_cnt cyc %0d got %0d exp %0d", k, run_cnt, (k >= 16) ? 15 : 14);
                end
            end
        end
        req = 1'b0;
        repeat (6) tick();
        checks++;
        if (run_cnt !== 4'd15 || clk_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle_hold got cnt=%0d en=%b busy=%b exp 15 0 0", run_cnt, clk_en, busy);
        end
        req = 1'b1;
        tick();
        checks++;
        if (run_cnt !== 4'd0 || clk_en !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear got cnt=%0d en=%b exp 0 1", run_cnt, clk_en);
        end
        tick();
        checks++;
        if (run_cnt !== 4'd1) begin
            errors++;
            $display("FAIL sat_restart got cnt=%0d exp 1", run_cnt);
        end
    endtask

    task automatic test_scan_reset();
        do_reset();
        scan_en = 1'b1;
        #1;
        checks++;
        if (clk_en !== 1'b1 || ack !== 1'b0 || busy !== 1'b0 || run_cnt !== 4'd0) begin
            errors++;
            $display("FAIL scan_idle got en=%b ack=%b busy=%b cnt=%0d exp 1 0 0 0", clk_en, ack, busy, run_cnt);
        end
        tick();
        tick();
        checks++;
        if (clk_en !== 1'b1 || ack !== 1'b0 || busy !== 1'b0 || run_cnt !== 4'd0) begin
            errors++;
            $display("FAIL scan_no_fsm got en=%b ack=%b busy=%b cnt=%0d exp 1 0 0 0", clk_en, ack, busy, run_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (clk_en !== 1'b1) begin
            errors++;
            $display("FAIL scan_in_reset got en=%b exp 1", clk_en);
        end
        scan_en = 1'b0;
        #1;
        checks++;
        if (clk_en !== 1'b0) begin
            errors++;
            $display("FAIL noscan_in_reset got en=%b exp 0", clk_en);
        end
        tick();
        reset = 1'b0;
        req   = 1'b1;
        repeat (6) tick();
        checks++;
        if (ack !== 1'b1 || clk_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_active got ack=%b en=%b exp 1 1", ack, clk_en);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || clk_en !== 1'b0 || busy !== 1'b0 || run_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got ack=%b en=%b busy=%b cnt=%0d exp 0 0 0 0", ack, clk_en, busy, run_cnt);
        end
        scan_en = 1'b1;
        #1;
        checks++;
        if (clk_en !== 1'b1 || ack !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_scan got en=%b ack=%b exp 1 0", clk_en, ack);
        end
        req     = 1'b0;
        scan_en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        scan_en = 1'b0;
        test_reset();
        test_warmup();
        test_release();
        test_abort();
        test_rerequest();
        test_saturate();
        test_scan_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
